// File: rtl/plp_loader_pkg.sv
// Shared types and default protocol bytes for the program loader.
// Imported by the loader top and its byte-packing sub-module.
package plp_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    RESP
  } state_t;

  localparam logic [7:0] CMD_LOAD_DEF = 8'hA5;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

endpackage

// File: rtl/loader_word_pack.sv
// Packs a byte stream into 32-bit big-endian words; word_vld flags the cycle
// the 4th byte arrives, with the completed word presented alongside it.
module loader_word_pack
  import plp_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [1:0]  lane_p0;
  logic [23:0] shift_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_p0 <= 2'd0;
    end else if (clr) begin
      lane_p0 <= 2'd0;
    end else if (byte_vld) begin
      lane_p0 <= lane_p0 + 2'd1;
    end
  end

  // Only the three most recent bytes are kept; the 4th completes the word directly.
  always_ff @(posedge clk) begin
    if (byte_vld) begin
      shift_p0 <= {shift_p0[15:0], byte_data};
    end
  end

  assign word_vld = byte_vld && (lane_p0 == 2'd3);
  assign word     = {shift_p0, byte_data};

endmodule

// File: rtl/prog_loader.sv
// Program-image loader: parses the UART load frame, writes words to program
// memory from address 0 upward and answers with ACK or NAK.
module prog_loader
  import plp_loader_pkg::*;
#(
  parameter int         ADDR_W   = 9,
  parameter logic [7:0] CMD_LOAD = CMD_LOAD_DEF,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] DEPTH_L = 17'(1 << ADDR_W);

  state_t          state;
  logic [15:0]     count;
  logic [ADDR_W:0] index;
  logic [7:0]      csum;
  logic            pack_clr;
  logic            pack_vld;
  logic            word_vld;
  logic [31:0]     word;
  logic [15:0]     cnt_full;
  logic [16:0]     next_index;

  assign pack_clr   = rx_valid && (state == IDLE) && (rx_data == CMD_LOAD);
  assign pack_vld   = rx_valid && (state == DATA);
  assign cnt_full   = {count[15:8], rx_data};
  assign next_index = 17'(index) + 17'd1;

  loader_word_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pack_clr),
    .byte_vld  (pack_vld),
    .byte_data (rx_data),
    .word_vld  (word_vld),
    .word      (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      index     <= '0;
      csum      <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (pack_clr) begin
            state <= CNT_HI;
            busy  <= 1'b1;
            error <= 1'b0;
            index <= '0;
            csum  <= '0;
          end
        end
        CNT_HI: begin
          if (rx_valid) begin
            count[15:8] <= rx_data;
            state       <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (rx_valid) begin
            count[7:0] <= rx_data;
            if (cnt_full == 16'd0) begin
              state <= CSUM;
            end else if ({1'b0, cnt_full} > DEPTH_L) begin
              state    <= RESP;
              tx_valid <= 1'b1;
              tx_data  <= NAK_BYTE;
              error    <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            csum <= csum ^ rx_data;
            // Write lands the cycle after the 4th byte; index moves on at the same edge.
            if (word_vld) begin
              mem_we    <= 1'b1;
              mem_addr  <= index[ADDR_W-1:0];
              mem_wdata <= word;
              index     <= index + (ADDR_W+1)'(1);
              if (next_index == {1'b0, count}) begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (rx_valid) begin
            state    <= RESP;
            tx_valid <= 1'b1;
            if (rx_data == csum) begin
              tx_data <= ACK_BYTE;
            end else begin
              tx_data <= NAK_BYTE;
              error   <= 1'b1;
            end
          end
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= (tx_data == ACK_BYTE);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
